// File: rtl/rv32v_vcfg_spec_queue_if.sv
// rv32v_vcfg_spec_queue_if
//   Bundle of the decode/execute/mem/CSR signals around the speculative
//   vector-configuration queue.
//   master : pipeline side (drives alloc/resolve/commit/flush, vset* operands,
//            architectural CSRs; observes full, vl_result and the shadow).
//   slave  : the queue itself.
interface rv32v_vcfg_spec_queue_if;
  logic        flush;
  logic        alloc;
  logic        full;
  logic        resolve;
  logic [31:0] vtype_spec;
  logic [31:0] avl_spec;
  logic [1:0]  avl_mode;
  logic [31:0] vl_result;
  logic        commit;
  logic [31:0] vtype_arch;
  logic [31:0] vl_arch;
  logic [31:0] vtype_shadow;
  logic [31:0] vl_shadow;
  logic        shadow_valid;

  modport master (
    output flush, alloc, resolve, vtype_spec, avl_spec, avl_mode, commit,
           vtype_arch, vl_arch,
    input  full, vl_result, vtype_shadow, vl_shadow, shadow_valid
  );

  modport slave (
    input  flush, alloc, resolve, vtype_spec, avl_spec, avl_mode, commit,
           vtype_arch, vl_arch,
    output full, vl_result, vtype_shadow, vl_shadow, shadow_valid
  );
endinterface

// File: rtl/rv32v_vcfg_spec_queue.sv
// rv32v_vcfg_spec_queue
//   DEPTH-entry in-order queue of speculative vtype/vl configurations.
//   Entries are appended by decode (alloc), filled in order by execute
//   (resolve, vl_result is the combinational vl of the resolving entry) and
//   retired in order by mem (commit). flush empties the queue.
// Ports
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : rv32v_vcfg_spec_queue_if.slave
//     flush/alloc/resolve/commit   : queue operations
//     vtype_spec/avl_spec/avl_mode : operands of the resolving vset*
//     vtype_arch/vl_arch           : architectural CSRs
//     full                         : count == DEPTH
//     vl_result                    : vl computed for the resolving entry
//     vtype_shadow/vl_shadow       : configuration decode must use
//     shadow_valid                 : low while the youngest entry is unresolved
module rv32v_vcfg_spec_queue #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned ELEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic CLK,
  input  logic nRST,
  rv32v_vcfg_spec_queue_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [31:0] vtype_q [DEPTH];
  logic [31:0] vl_q    [DEPTH];
  logic        res_q   [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;
  // Number of resolved, uncommitted entries (head .. rptr-1). Kept explicitly
  // so "all resolved" and "none resolved" stay distinguishable when full.
  cnt_t rcnt_q, rcnt_d;

  // ---------------------------------------------------------------------------
  // vset* evaluation
  // ---------------------------------------------------------------------------
  logic [2:0]  vsew, vlmul;
  logic [31:0] base, vlmax, sew_bits, prior_vl, res_vl, res_vtype;
  logic        vill;
  ptr_t        prior_idx;

  assign vsew      = bus.vtype_spec[5:3];
  assign vlmul     = bus.vtype_spec[2:0];
  assign sew_bits  = 32'd8 << vsew;
  assign prior_idx = rptr_q - ptr_t'(1);
  assign prior_vl  = (rcnt_q == '0) ? bus.vl_arch : vl_q[prior_idx];

  always_comb begin
    base  = 32'(VLEN) >> ({1'b0, vsew} + 4'd3);
    vlmax = '0;
    case (vlmul)
      3'b000, 3'b001, 3'b010, 3'b011: vlmax = base << vlmul[1:0];
      3'b111:                         vlmax = base >> 1;
      3'b110:                         vlmax = base >> 2;
      3'b101:                         vlmax = base >> 3;
      default:                        vlmax = '0;
    endcase
  end

  assign vill = bus.vtype_spec[31] || (bus.vtype_spec[30:8] != '0) ||
                (vlmul == 3'b100) || (vsew > 3'b011) ||
                (sew_bits > 32'(ELEN)) || (vlmax == '0);

  always_comb begin
    res_vl = '0;
    if (!vill) begin
      case (bus.avl_mode)
        2'b10:   res_vl = vlmax;
        2'b01:   res_vl = (prior_vl < vlmax) ? prior_vl : vlmax;
        default: res_vl = (bus.avl_spec < vlmax) ? bus.avl_spec : vlmax;
      endcase
    end
  end

  assign res_vtype     = vill ? VILL_VTYPE : {24'b0, bus.vtype_spec[7:0]};
  assign bus.vl_result = res_vl;

  // ---------------------------------------------------------------------------
  // Queue control
  // ---------------------------------------------------------------------------
  logic full_w, has_unres, alloc_ok, resolve_ok, commit_ok;

  assign full_w     = (count_q == cnt_t'(DEPTH));
  assign has_unres  = (count_q != rcnt_q);
  assign alloc_ok   = bus.alloc   && !full_w          && !bus.flush;
  assign resolve_ok = bus.resolve && has_unres        && !bus.flush;
  // Only an entry resolved in an earlier cycle may retire.
  assign commit_ok  = bus.commit  && (rcnt_q != '0)   && !bus.flush;

  always_comb begin
    head_d  = head_q + ptr_t'(commit_ok);
    tail_d  = tail_q + ptr_t'(alloc_ok);
    rptr_d  = rptr_q + ptr_t'(resolve_ok);
    count_d = count_q + cnt_t'(alloc_ok) - cnt_t'(commit_ok);
    rcnt_d  = rcnt_q + cnt_t'(resolve_ok) - cnt_t'(commit_ok);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      rcnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rcnt_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vtype_q[i] <= VILL_VTYPE;
        vl_q[i]    <= '0;
        res_q[i]   <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rcnt_q  <= rcnt_d;
      if (bus.flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          vtype_q[i] <= VILL_VTYPE;
          vl_q[i]    <= '0;
          res_q[i]   <= 1'b0;
        end
      end else begin
        // alloc writes at tail, resolve at rptr; these never coincide while
        // an unresolved entry exists and the queue is not full.
        if (alloc_ok) res_q[tail_q] <= 1'b0;
        if (resolve_ok) begin
          vtype_q[rptr_q] <= res_vtype;
          vl_q[rptr_q]    <= res_vl;
          res_q[rptr_q]   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow outputs
  // ---------------------------------------------------------------------------
  ptr_t young_idx;
  assign young_idx = tail_q - ptr_t'(1);

  assign bus.full         = full_w;
  assign bus.shadow_valid = (count_q == '0) ? 1'b1 : res_q[young_idx];
  assign bus.vtype_shadow = (count_q == '0) ? bus.vtype_arch : vtype_q[young_idx];
  assign bus.vl_shadow    = (count_q == '0) ? bus.vl_arch    : vl_q[young_idx];

  // ---------------------------------------------------------------------------
  // Protocol errors: the operation is dropped and these fire in simulation.
  // ---------------------------------------------------------------------------
  a_alloc_full: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.alloc && !bus.flush && full_w))
    else $error("alloc while full");
  a_resolve_none: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.resolve && !bus.flush && !has_unres))
    else $error("resolve with no unresolved entry");
  a_commit_empty: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.commit && !bus.flush && (count_q == '0)))
    else $error("commit while empty");
  a_commit_unres: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.commit && !bus.flush && (count_q != '0) && (rcnt_q == '0)))
    else $error("commit of unresolved head");

endmodule
